// File: rtl/quadrant_paint_sequencer.sv
// quadrant_paint_sequencer
// Advances a one-hot quadrant selector on each push-button release and
// fills the newly selected quadrant of the framebuffer with a latched colour
// through a req/ack write port.
//
// Optional feature: define QUADRANT_PAINT_DEBOUNCE_EN to insert a debounce
// filter (DEB_CYCLES stable cycles) after the button synchronizer.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-high reset
//   boton    in   raw push-button (async), 1 = pressed
//   color    in   RGB332 fill colour, sampled when a fill starts
//   quad     out  one-hot quadrant (bit0 TL, bit1 TR, bit2 BL, bit3 BR)
//   wr_req   out  pixel write request
//   wr_ack   in   write accepted on a rising edge while wr_req is high
//   wr_addr  out  pixel address y*H_RES + x
//   wr_data  out  pixel colour
//   busy     out  high while filling
//   done     out  one-cycle pulse after the last pixel is accepted
`timescale 1ns/1ps

module quadrant_paint_sequencer #(
  parameter int unsigned H_RES      = 640,
  parameter int unsigned V_RES      = 480,
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              boton,
  input  logic [7:0]        color,
  output logic [3:0]        quad,
  output logic              wr_req,
  input  logic              wr_ack,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done
);

  localparam int unsigned HALF_H = H_RES / 2;
  localparam int unsigned HALF_V = V_RES / 2;
  localparam int unsigned X_W    = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int unsigned Y_W    = (V_RES > 1) ? $clog2(V_RES) : 1;

  // Row base of the bottom half and the per-row stride, both constants.
  localparam logic [ADDR_W-1:0] BOT_BASE = ADDR_W'(HALF_V * H_RES);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_RES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state;
  logic              sync1;
  logic              sync2;
  logic              btn_f;
  logic              btn_q;
  logic              rel_evt;

  logic [X_W-1:0]    x;
  logic [X_W-1:0]    x_org;
  logic [X_W-1:0]    x_end;
  logic [Y_W-1:0]    y;
  logic [Y_W-1:0]    y_end;
  logic [ADDR_W-1:0] row_base;

  logic [3:0]        quad_nxt;
  logic [X_W-1:0]    org_x;
  logic [Y_W-1:0]    org_y;
  logic [ADDR_W-1:0] org_base;
  logic              row_end;
  logic              last_px;
  logic [X_W-1:0]    x_nxt;
  logic [ADDR_W-1:0] base_nxt;

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= boton;
      sync2 <= sync1;
    end
  end

`ifdef QUADRANT_PAINT_DEBOUNCE_EN
  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

  logic [CNT_W-1:0] deb_cnt;

  // btn_f follows the synchronized button only after DEB_CYCLES consecutive
  // cycles of disagreement; any agreement restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_cnt <= '0;
      btn_f   <= 1'b0;
    end else if (sync2 != btn_f) begin
      if (deb_cnt == CNT_W'(DEB_CYCLES - 1)) begin
        btn_f   <= sync2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + CNT_W'(1);
      end
    end else begin
      deb_cnt <= '0;
    end
  end
`else
  assign btn_f = sync2;
`endif

  // Release = filtered button falls.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_q <= 1'b0;
    end else begin
      btn_q <= btn_f;
    end
  end

  assign rel_evt = btn_q & ~btn_f;

  // Next quadrant, its origin, and the pixel-walk increment.
  always_comb begin
    quad_nxt = {quad[2:0], quad[3]};
    org_x    = (quad_nxt[1] | quad_nxt[3]) ? X_W'(HALF_H) : '0;
    org_y    = (quad_nxt[2] | quad_nxt[3]) ? Y_W'(HALF_V) : '0;
    org_base = (quad_nxt[2] | quad_nxt[3]) ? BOT_BASE : '0;
    row_end  = (x == x_end);
    last_px  = row_end && (y == y_end);
    x_nxt    = row_end ? x_org : x + X_W'(1);
    base_nxt = row_end ? row_base + ROW_STEP : row_base;
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      quad     <= 4'b0001;
      wr_req   <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      x        <= '0;
      x_org    <= '0;
      x_end    <= '0;
      y        <= '0;
      y_end    <= '0;
      row_base <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rel_evt) begin
            quad     <= quad_nxt;
            wr_data  <= color;
            x        <= org_x;
            x_org    <= org_x;
            x_end    <= org_x + X_W'(HALF_H - 1);
            y        <= org_y;
            y_end    <= org_y + Y_W'(HALF_V - 1);
            row_base <= org_base;
            wr_addr  <= org_base + ADDR_W'(org_x);
            wr_req   <= 1'b1;
            busy     <= 1'b1;
            state    <= S_FILL;
          end
        end
        S_FILL: begin
          if (wr_ack) begin
            if (last_px) begin
              wr_req <= 1'b0;
              busy   <= 1'b0;
              done   <= 1'b1;
              state  <= S_DONE;
            end else begin
              x        <= x_nxt;
              row_base <= base_nxt;
              wr_addr  <= base_nxt + ADDR_W'(x_nxt);
              if (row_end) begin
                y <= y + Y_W'(1);
              end
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_quadrant_paint_sequencer.sv
// Testbench for quadrant_paint_sequencer (H_RES=8, V_RES=4, DEB_CYCLES=4).
// Stimulus pushes the expected pixel writes of each fill into a queue; a
// negedge monitor pops and compares on every accepted write and checks the
// done pulse and the stall-stability of the write port.
`timescale 1ns/1ps

module tb_quadrant_paint_sequencer;

  localparam int unsigned H   = 8;
  localparam int unsigned V   = 4;
  localparam int unsigned AW  = 5;
  localparam int unsigned DEB = 4;
`ifdef QUADRANT_PAINT_DEBOUNCE_EN
  localparam int LAT = 3 + DEB;
`else
  localparam int LAT = 3;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          boton;
  logic [7:0]    color;
  logic [3:0]    quad;
  logic          wr_req;
  logic          wr_ack;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          busy;
  logic          done;

  quadrant_paint_sequencer #(
    .H_RES(H), .V_RES(V), .ADDR_W(AW), .DEB_CYCLES(DEB)
  ) dut (
    .clk(clk), .reset(reset), .boton(boton), .color(color), .quad(quad),
    .wr_req(wr_req), .wr_ack(wr_ack), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       addr;
    int       data;
    bit       last;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  int            checks = 0;
  int            errors = 0;
  int            ack_mode = 1;   // 0 low, 1 high, 2 random
  int            qi = 0;         // model: index of the current quadrant
  bit            expect_done = 1'b0;
  bit            stalled = 1'b0;
  logic [AW-1:0] held_addr;
  logic [7:0]    held_data;
  int            ncyc;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: every pixel of quadrant q in raster order.
  task automatic push_fill(input int q, input int c);
    int x0;
    int y0;
    exp_t e;
    x0 = (q == 1 || q == 3) ? int'(H / 2) : 0;
    y0 = (q >= 2) ? int'(V / 2) : 0;
    for (int yy = y0; yy < y0 + int'(V / 2); yy++) begin
      for (int xx = x0; xx < x0 + int'(H / 2); xx++) begin
        e.addr = yy * int'(H) + xx;
        e.data = c;
        e.last = (yy == y0 + int'(V / 2) - 1) && (xx == x0 + int'(H / 2) - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  // Press for 'hold' cycles, release, and check the exact release latency.
  task automatic release_fill(input logic [7:0] c, input int hold);
    int old_q;
    color = c;
    boton = 1'b1;
    tick(hold);
    chk("quad_hold_while_pressed", int'(quad), 1 << qi);
    boton = 1'b0;
    old_q = qi;
    qi = (qi + 1) % 4;
    push_fill(qi, int'(c));
    tick(LAT - 1);
    chk("quad_before_latency", int'(quad), 1 << old_q);
    chk("wr_req_before_latency", int'(wr_req), 0);
    tick(1);
    chk("quad_after_release", int'(quad), 1 << qi);
    chk("wr_req_after_release", int'(wr_req), 1);
    chk("busy_after_release", int'(busy), 1);
  endtask

  // Run until busy falls (bounded); n = cycles spent busy from here.
  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 2000 && busy; i++) begin
      tick(1);
      n++;
    end
    chk("fill_timeout_busy", int'(busy), 0);
    tick(2);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  // wr_ack driver, updated 2 time units after each rising edge.
  initial begin
    wr_ack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ack_mode)
        0:       wr_ack = 1'b0;
        1:       wr_ack = 1'b1;
        default: wr_ack = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: scoreboard pops, done timing, stall stability.
  always @(negedge clk) begin
    if (reset) begin
      stalled     = 1'b0;
      expect_done = 1'b0;
    end else begin
      if (expect_done) begin
        chk("done_after_last_ack", int'(done), 1);
        chk("busy_low_with_done", int'(busy), 0);
        expect_done = 1'b0;
      end else begin
        chk("no_spurious_done", int'(done), 0);
      end
      if (stalled && wr_req) begin
        chk("stall_addr_stable", int'(wr_addr), int'(held_addr));
        chk("stall_data_stable", int'(wr_data), int'(held_data));
      end
      if (wr_req && wr_ack) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write_addr", int'(wr_addr), -1);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", int'(wr_addr), mon_e.addr);
          chk("wr_data", int'(wr_data), mon_e.data);
          if (mon_e.last) expect_done = 1'b1;
        end
      end
      stalled   = wr_req && !wr_ack;
      held_addr = wr_addr;
      held_data = wr_data;
    end
  end

  initial begin
    logic [AW-1:0] saved_addr;
    int            exp_glitch_q;

    reset = 1'b1;
    boton = 1'b0;
    color = 8'h00;
    tick(3);
    reset = 1'b0;
    chk("reset_wr_addr", int'(wr_addr), 0);
    chk("reset_wr_data", int'(wr_data), 0);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("reset_quad", int'(quad), 1);
      chk("reset_wr_req", int'(wr_req), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
    end

    // First fill: ack tied high, one pixel per cycle.
    ack_mode = 1;
    release_fill(8'hE0, 12);
    wait_idle(ncyc);
    chk("fill_cycles_ack_high", ncyc, int'((H / 2) * (V / 2)));

    // Remaining quadrants and the wrap back to quadrant 1.
    ack_mode = 2;
    release_fill(8'($urandom), 10);
    wait_idle(ncyc);
    ack_mode = 1;
    release_fill(8'($urandom), 10);
    wait_idle(ncyc);
    ack_mode = 2;
    release_fill(8'($urandom), 11);
    wait_idle(ncyc);

    // Ack held low for 5 cycles mid-fill.
    ack_mode = 1;
    release_fill(8'h1C, 10);
    tick(2);
    ack_mode = 0;
    tick(1);
    saved_addr = wr_addr;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("stall_wr_req", int'(wr_req), 1);
      chk("stall_addr_hold", int'(wr_addr), int'(saved_addr));
    end
    ack_mode = 1;
    wait_idle(ncyc);

    // Release during a fill is dropped.
    ack_mode = 0;
    release_fill(8'h03, 10);
    color = 8'hFF;
    boton = 1'b1;
    tick(12);
    boton = 1'b0;
    tick(LAT + 3);
    chk("midfill_release_quad", int'(quad), 1 << qi);
    chk("midfill_release_busy", int'(busy), 1);
    ack_mode = 1;
    wait_idle(ncyc);
    tick(10);
    chk("single_fill_busy", int'(busy), 0);
    chk("single_fill_quad", int'(quad), 1 << qi);

    // Reset mid-fill aborts without a done pulse.
    ack_mode = 1;
    release_fill(8'h55, 10);
    tick(2);
    ack_mode = 0;
    tick(1);
    reset = 1'b1;
    exp_q.delete();
    qi = 0;
    tick(1);
    chk("abort_wr_req", int'(wr_req), 0);
    chk("abort_quad", int'(quad), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    reset = 1'b0;
    ack_mode = 1;
    tick(10);
    chk("abort_idle_quad", int'(quad), 1);

    // Two-cycle glitch: filtered with debounce, a release without it.
    color = 8'hA5;
    boton = 1'b1;
    tick(2);
    boton = 1'b0;
`ifdef QUADRANT_PAINT_DEBOUNCE_EN
    exp_glitch_q = qi;
`else
    exp_glitch_q = (qi + 1) % 4;
    push_fill(exp_glitch_q, 8'hA5);
`endif
    qi = exp_glitch_q;
    tick(LAT);
    chk("glitch_quad", int'(quad), 1 << qi);
    wait_idle(ncyc);
    tick(20);
    chk("glitch_quad_final", int'(quad), 1 << qi);

    // Randomized fills with random ack and hold times.
    for (int k = 0; k < 5; k++) begin
      ack_mode = 2;
      release_fill(8'($urandom), 8 + int'($urandom_range(0, 6)));
      wait_idle(ncyc);
      tick(int'($urandom_range(0, 4)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
